// File: rtl/wall_field_ctrl_pkg.sv
// Shared game constants and the wall slot record used by the wall field engine.
`default_nettype none

package wall_field_ctrl_pkg;

  localparam int GAME_SCREEN_W = 160;
  localparam int GAME_SCREEN_H = 120;
  localparam int GAME_PLAYER_X = 40;
  localparam int GAME_X_W      = 8;
  localparam int GAME_Y_W      = 7;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic                active;
    logic [GAME_X_W-1:0] x;
    logic [GAME_Y_W-1:0] hole_y;
  } wall_slot_t;

endpackage

`default_nettype wire

// File: rtl/wall_field_ctrl_if.sv
// Control and draw-read bundle between game FSM / VGA datapath and the wall field.
`default_nettype none

interface wall_field_ctrl_if #(
  parameter int NUM_WALLS = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int SCORE_W   = 10
);
  localparam int IDX_W = $clog2(NUM_WALLS);

  logic               tick;
  logic               enable;
  logic               clear;
  logic [IDX_W-1:0]   rd_idx;
  logic [X_W-1:0]     rd_x;
  logic [Y_W-1:0]     rd_hole_y;
  logic               rd_active;
  logic               pass_pulse;
  logic [SCORE_W-1:0] score;
  logic [3:0]         speed;

  modport master (
    output tick, enable, clear, rd_idx,
    input  rd_x, rd_hole_y, rd_active, pass_pulse, score, speed
  );

  modport slave (
    input  tick, enable, clear, rd_idx,
    output rd_x, rd_hole_y, rd_active, pass_pulse, score, speed
  );

endinterface

`default_nettype wire

// File: rtl/wall_lfsr.sv
// Free-running 8-bit Galois LFSR; exposes its low OUT_W bits as the random value.
`default_nettype none

module wall_lfsr
  import wall_field_ctrl_pkg::*;
#(
  parameter int OUT_W = 6
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  output logic      [OUT_W-1:0] o_rnd
);

  logic [7:0] r_state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= LFSR_SEED;
    end else begin
      r_state <= {1'b0, r_state[7:1]} ^ (r_state[0] ? LFSR_TAPS : 8'h00);
    end
  end

  assign o_rnd = r_state[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/wall_field_ctrl.sv
// Multi-wall obstacle engine: scrolls, spawns and retires walls, counts passes and speed.
`default_nettype none

module wall_field_ctrl
  import wall_field_ctrl_pkg::*;
#(
  parameter int NUM_WALLS     = 4,
  parameter int X_W           = GAME_X_W,
  parameter int Y_W           = GAME_Y_W,
  parameter int SCREEN_W      = GAME_SCREEN_W,
  parameter int PLAYER_X      = GAME_PLAYER_X,
  parameter int SPAWN_GAP     = 10,
  parameter int HOLE_MIN      = 10,
  parameter int HOLE_RANGE_W  = 6,
  parameter int SPEED_INIT    = 4,
  parameter int SPEED_MAX     = 8,
  parameter int SPEEDUP_EN    = 1,
  parameter int SPEEDUP_EVERY = 5,
  parameter int SCORE_W       = 10
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  wall_field_ctrl_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_WALLS);
  localparam int CNT_W = $clog2(NUM_WALLS + 1);

  localparam logic [X_W-1:0] C_SCREEN_W   = X_W'(SCREEN_W);
  localparam logic [X_W-1:0] C_PLAYER_X   = X_W'(PLAYER_X);
  localparam logic [7:0]     C_GAP_LAST   = 8'(SPAWN_GAP - 1);
  localparam logic [3:0]     C_SPEED_INIT = 4'(SPEED_INIT);
  localparam logic [3:0]     C_SPEED_MAX  = 4'(SPEED_MAX);
  localparam logic [7:0]     C_EVERY      = 8'(SPEEDUP_EVERY);

  wall_slot_t [NUM_WALLS-1:0] r_slot;
  logic       [SCORE_W-1:0]   r_score;
  logic       [3:0]           r_speed;
  logic       [7:0]           r_spawn_cnt;
  logic       [7:0]           r_pass_cnt;
  logic                       r_pass_pulse;

  wall_slot_t [NUM_WALLS-1:0] w_next;
  wall_slot_t [NUM_WALLS-1:0] w_upd;
  logic       [NUM_WALLS-1:0] w_pass;
  logic       [HOLE_RANGE_W-1:0] w_rnd;
  logic                       w_update;
  logic                       w_spawn;
  logic                       w_free_found;
  logic       [IDX_W-1:0]     w_free_idx;
  logic       [CNT_W-1:0]     w_npass;
  logic       [SCORE_W:0]     w_score_sum;
  logic       [SCORE_W-1:0]   w_score_nx;
  logic       [7:0]           w_pc_sum;
  logic       [7:0]           w_pc_nx;
  logic       [3:0]           w_speed_nx;
  logic       [7:0]           w_cnt_nx;

  wall_lfsr #(
    .OUT_W (HOLE_RANGE_W)
  ) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .o_rnd  (w_rnd)
  );

  assign w_update = bus.tick & bus.enable;

  for (genvar gi = 0; gi < NUM_WALLS; gi++) begin : g_slot
    wall_slot_t w_nx;
    logic       w_ps;

    always_comb begin
      w_nx = r_slot[gi];
      w_ps = 1'b0;
      if (r_slot[gi].active) begin
        // A wall that cannot move a full step leaves the screen; x is kept as-is.
        if (r_slot[gi].x < X_W'(r_speed)) begin
          w_nx.active = 1'b0;
        end else begin
          w_nx.x = r_slot[gi].x - X_W'(r_speed);
          w_ps   = (r_slot[gi].x >= C_PLAYER_X) && (w_nx.x < C_PLAYER_X);
        end
      end
    end

    assign w_next[gi] = w_nx;
    assign w_pass[gi] = w_ps;
  end

  // Free slot search uses pre-update activity so a wall retired now is not reused now.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_WALLS - 1; i >= 0; i--) begin
      if (!r_slot[i].active) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign w_spawn  = (r_spawn_cnt == C_GAP_LAST);
  assign w_cnt_nx = w_spawn ? 8'd0 : r_spawn_cnt + 8'd1;

  always_comb begin
    w_upd = w_next;
    if (w_spawn && w_free_found) begin
      w_upd[w_free_idx].active = 1'b1;
      w_upd[w_free_idx].x      = C_SCREEN_W;
      w_upd[w_free_idx].hole_y = Y_W'(HOLE_MIN) + Y_W'(w_rnd);
    end
  end

  always_comb begin
    w_npass = '0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      w_npass = w_npass + CNT_W'(w_pass[i]);
    end
  end

  assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(w_npass);
  assign w_score_nx  = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
  assign w_pc_sum    = r_pass_cnt + 8'(w_npass);

  always_comb begin
    w_pc_nx    = r_pass_cnt;
    w_speed_nx = r_speed;
    if (SPEEDUP_EN != 0) begin
      if (w_pc_sum >= C_EVERY) begin
        w_pc_nx = w_pc_sum - C_EVERY;
        if (r_speed < C_SPEED_MAX) begin
          w_speed_nx = r_speed + 4'd1;
        end
      end else begin
        w_pc_nx = w_pc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot       <= '0;
      r_score      <= '0;
      r_speed      <= C_SPEED_INIT;
      r_spawn_cnt  <= '0;
      r_pass_cnt   <= '0;
      r_pass_pulse <= 1'b0;
    end else if (bus.clear) begin
      r_slot       <= '0;
      r_score      <= '0;
      r_speed      <= C_SPEED_INIT;
      r_spawn_cnt  <= '0;
      r_pass_cnt   <= '0;
      r_pass_pulse <= 1'b0;
    end else if (w_update) begin
      r_slot       <= w_upd;
      r_score      <= w_score_nx;
      r_speed      <= w_speed_nx;
      r_spawn_cnt  <= w_cnt_nx;
      r_pass_cnt   <= w_pc_nx;
      r_pass_pulse <= |w_pass;
    end else begin
      r_pass_pulse <= 1'b0;
    end
  end

  always_comb begin
    bus.rd_x      = '0;
    bus.rd_hole_y = '0;
    bus.rd_active = 1'b0;
    if (32'(bus.rd_idx) < NUM_WALLS) begin
      bus.rd_x      = r_slot[bus.rd_idx].x;
      bus.rd_hole_y = r_slot[bus.rd_idx].hole_y;
      bus.rd_active = r_slot[bus.rd_idx].active;
    end
  end

  assign bus.pass_pulse = r_pass_pulse;
  assign bus.score      = r_score;
  assign bus.speed      = r_speed;

endmodule

`default_nettype wire
